pipeline_stage_skid: RTL and testbench
======================================

Name: pipeline_stage_skid

Overview:
- Generic, parametrised inter-stage pipeline register for the RV32E core.
- Replaces the hand-written per-stage registers with a single payload bus.
- Adds a valid/ready handshake, a 2-entry skid buffer for full throughput without a combinational ready path, synchronous flush, and invalid-entry kill masking.
- Sits between any two pipeline stages (e.g. MEMPREP→MEMEX); upstream packs stage signals into one payload vector.

Parameters:
PAYLOAD_W, 128, width of the packed stage payload.
KILL_MASK, {PAYLOAD_W{1'b0}}, payload bits forced to 0 when an invalid entry is stored (e.g. regfile_we, lsu_we, itcm_we positions).
STALL_CNT_W, 16, width of the optional stall counter.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
in_valid  input  1  upstream entry present
in_ready  output  1  stage can accept an entry this cycle
in_invalid  input  1  entry is a bubble/squashed instruction
in_payload  input  PAYLOAD_W  upstream packed signals
out_valid  output  1  entry present to downstream
out_ready  input  1  downstream consumes entry this cycle
out_invalid  output  1  invalid tag of presented entry
out_payload  output  PAYLOAD_W  presented payload (main register)
flush  input  1  synchronous discard of all held entries
occupancy  output  2  entries held: 0, 1 or 2
stall_cycles  output  STALL_CNT_W  present only with PIPE_STAGE_PERF_EN

Behaviour:
- One clock (clk); reset is asynchronous and active-high (rst). Reset forces: state EMPTY, out_valid=0, out_invalid=0, out_payload=0, skid regs=0, occupancy=0, stall_cycles=0. in_ready=1 out of reset.
- accept = in_valid & in_ready; drain = out_valid & out_ready.
- in_ready = (state != FULL); depends only on registered state, with no combinational path from out_ready.
- out_valid = (state != EMPTY); out_payload/out_invalid are driven directly from the main register.
- States:
  - EMPTY: accept → HALF, main ← in.
  - HALF:
    - accept&drain → HALF, main ← in.
    - accept&!drain → FULL, skid ← in.
    - !accept&drain → EMPTY.
    - otherwise hold.
  - FULL: drain → HALF, main ← skid; otherwise hold (no accept possible).
- Latency: 1 cycle in→out when EMPTY, or when in HALF with simultaneous drain. Sustained throughput: 1 entry/cycle.
- Kill masking: on any write into main or skid with in_invalid=1, the stored payload is in_payload & ~KILL_MASK and the stored invalid flag is 1. Valid entries are stored unmodified. Invalid entries still occupy a slot and handshake normally.
- Ordering: strict FIFO; the skid entry always follows the main entry.
- Flush: highest priority over all events.
  - Next state EMPTY; any entry accepted in the same cycle is discarded.
  - A drain in the flush cycle still counts as consumed downstream.
  - Payload registers keep stale data (don't care) and are never presented because out_valid=0.
- Reset mid-operation: rst asserted at any time clears all state immediately (asynchronous). The first accept is possible on the first clk edge after release.
- occupancy: EMPTY=0, HALF=1, FULL=2.

Optional Feature:
PIPE_STAGE_PERF_EN:
- Defined: stall_cycles increments each cycle with out_valid & !out_ready. It saturates at all-ones (no wrap), is cleared only by rst, and is unaffected by flush.
- Undefined: stall_cycles port and counter logic are absent; all other behaviour is identical.

Test Plan:
(PAYLOAD_W=32, KILL_MASK=32'h0000_0005 for all scenarios.)
- Streaming: out_ready=1; in_valid=1 for payloads 0x10,0x11,0x12 on consecutive cycles → same values on out_payload one cycle later each, out_valid continuous, occupancy never exceeds 1.
- Backpressure: out_ready=0, send 0xA0 then 0xA1 → occupancy=2, in_ready=0, in_valid held with 0xA2 not accepted; raise out_ready → outputs 0xA0, 0xA1, 0xA2 in order, nothing lost or duplicated.
- Kill mask: in_invalid=1, in_payload=0xFFFF_FFFF → out_payload=0xFFFF_FFFA, out_invalid=1; next entry in_invalid=0, payload 0xFFFF_FFFF → out_payload=0xFFFF_FFFF, out_invalid=0.
- Flush: FULL with 0xB0/0xB1 and in_valid=1 carrying 0xB2; assert flush one cycle → next cycle out_valid=0, occupancy=0, in_ready=1; 0xB0, 0xB1 and 0xB2 are never presented.
- Async reset: rst pulsed between clock edges while FULL → outputs zero immediately without a clock edge; after release, 0xC0 sent → appears 1 cycle later.
- Perf (macro defined, STALL_CNT_W=4): out_valid=1, out_ready=0 for 20 cycles → stall_cycles=15 and holds; flush → still 15; rst → 0.

Source files
------------

// File: rtl/pipeline_stage_skid.sv
// pipeline_stage_skid
// -------------------
// Inter-stage pipeline register with a valid/ready handshake. It holds up to
// two entries: the main register, which is presented downstream, and a skid
// register. The skid register absorbs the entry accepted in the cycle when
// downstream stalls. Because of this, in_ready depends only on registered
// state, so there is no combinational path from out_ready to in_ready.
// Throughput is one entry per cycle.
//
// Entries flagged invalid (bubbles or squashed instructions) are stored with
// the KILL_MASK bits of the payload forced to zero. Any write-enable style
// fields carried by a dead entry therefore can never fire downstream.
//
// Optional feature macro: PIPE_STAGE_PERF_EN
//   When defined, the stall_cycles port and a saturating stall counter are
//   present.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   in_valid     upstream entry present
//   in_ready     stage can accept an entry this cycle
//   in_invalid   entry is a bubble/squashed instruction
//   in_payload   upstream packed stage signals
//   out_valid    entry present to downstream
//   out_ready    downstream consumes entry this cycle
//   out_invalid  invalid tag of the presented entry
//   out_payload  presented payload (main register)
//   flush        synchronous discard of all held entries
//   occupancy    entries held: 0, 1 or 2
//   stall_cycles cycles with out_valid & !out_ready, saturating
//                (PIPE_STAGE_PERF_EN only)

module pipeline_stage_skid #(
  parameter int                   PAYLOAD_W   = 128,
  parameter logic [PAYLOAD_W-1:0] KILL_MASK   = {PAYLOAD_W{1'b0}},
  parameter int                   STALL_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_invalid,
  input  logic [PAYLOAD_W-1:0] in_payload,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_invalid,
  output logic [PAYLOAD_W-1:0] out_payload,
  input  logic                 flush,
  output logic [1:0]           occupancy
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [STALL_CNT_W-1:0] stall_cycles
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [PAYLOAD_W-1:0]   main_payload_q, main_payload_d;
  logic                   main_invalid_q, main_invalid_d;
  logic [PAYLOAD_W-1:0]   skid_payload_q, skid_payload_d;
  logic                   skid_invalid_q, skid_invalid_d;

  logic                   accept;
  logic                   drain;
  logic [PAYLOAD_W-1:0]   in_payload_masked;

  assign in_ready    = (state_q != FULL);
  assign out_valid   = (state_q != EMPTY);
  assign out_payload = main_payload_q;
  assign out_invalid = main_invalid_q;

  assign accept = in_valid & in_ready;
  assign drain  = out_valid & out_ready;

  // Dead entries lose their masked bits at write time. Both the main and the
  // skid register take this same masked value.
  assign in_payload_masked = in_invalid ? (in_payload & ~KILL_MASK) : in_payload;

  always_comb begin
    state_d        = state_q;
    main_payload_d = main_payload_q;
    main_invalid_d = main_invalid_q;
    skid_payload_d = skid_payload_q;
    skid_invalid_d = skid_invalid_q;

    if (flush) begin
      // Flush discards everything, including an entry offered this cycle.
      // The payload registers keep stale data; they are hidden because
      // out_valid is 0.
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d        = HALF;
            main_payload_d = in_payload_masked;
            main_invalid_d = in_invalid;
          end
        end
        HALF: begin
          if (accept && drain) begin
            main_payload_d = in_payload_masked;
            main_invalid_d = in_invalid;
          end else if (accept) begin
            // Downstream stalled while upstream delivered: park in skid.
            state_d        = FULL;
            skid_payload_d = in_payload_masked;
            skid_invalid_d = in_invalid;
          end else if (drain) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (drain) begin
            state_d        = HALF;
            main_payload_d = skid_payload_q;
            main_invalid_d = skid_invalid_q;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= EMPTY;
      main_payload_q <= '0;
      main_invalid_q <= 1'b0;
      skid_payload_q <= '0;
      skid_invalid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      main_payload_q <= main_payload_d;
      main_invalid_q <= main_invalid_d;
      skid_payload_q <= skid_payload_d;
      skid_invalid_q <= skid_invalid_d;
    end
  end

  always_comb begin
    case (state_q)
      HALF:    occupancy = 2'd1;
      FULL:    occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

`ifdef PIPE_STAGE_PERF_EN
  logic [STALL_CNT_W-1:0] stall_q, stall_d;

  // Saturates at all-ones. Only rst clears it; flush has no effect.
  always_comb begin
    stall_d = stall_q;
    if (out_valid && !out_ready && (stall_q != {STALL_CNT_W{1'b1}})) begin
      stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cycles = stall_q;
`else
  // No counter in this build; the width parameter is intentionally unused.
  logic [STALL_CNT_W-1:0] unused_stall_w;
  assign unused_stall_w = '0;
`endif

endmodule

// File: tb/tb_pipeline_stage_skid.sv
module tb_pipeline_stage_skid;

  localparam int PW = 32;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic          in_invalid;
  logic [PW-1:0] in_payload;
  logic          out_valid;
  logic          out_ready;
  logic          out_invalid;
  logic [PW-1:0] out_payload;
  logic          flush;
  logic [1:0]    occupancy;
`ifdef PIPE_STAGE_PERF_EN
  logic [SW-1:0] stall_cycles;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  pipeline_stage_skid #(
    .PAYLOAD_W  (PW),
    .KILL_MASK  (32'h0000_0005),
    .STALL_CNT_W(SW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_invalid  (in_invalid),
    .in_payload  (in_payload),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_invalid (out_invalid),
    .out_payload (out_payload),
    .flush       (flush),
    .occupancy   (occupancy)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .stall_cycles(stall_cycles)
`endif
  );

  typedef struct {
    logic          v;
    logic          inv;
    logic [PW-1:0] pay;
    logic          ordy;
    logic          fl;
    logic          e_valid;
    logic          e_inv;
    logic [PW-1:0] e_pay;
    logic          e_irdy;
    logic [1:0]    e_occ;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic add(input logic v, input logic inv, input logic [PW-1:0] pay,
                     input logic ordy, input logic fl, input logic e_valid,
                     input logic e_inv, input logic [PW-1:0] e_pay,
                     input logic e_irdy, input logic [1:0] e_occ);
    vec_t t;
    t.v = v; t.inv = inv; t.pay = pay; t.ordy = ordy; t.fl = fl;
    t.e_valid = e_valid; t.e_inv = e_inv; t.e_pay = e_pay;
    t.e_irdy = e_irdy; t.e_occ = e_occ;
    vecs.push_back(t);
  endtask

  task automatic drive(input logic v, input logic inv, input logic [PW-1:0] pay,
                       input logic ordy, input logic fl);
    in_valid = v; in_invalid = inv; in_payload = pay; out_ready = ordy; flush = fl;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
    #12;
    // Reset state
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_invalid", {31'd0, out_invalid}, 32'd0);
    chk("rst_out_payload", out_payload, 32'd0);
    chk("rst_occupancy", {30'd0, occupancy}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
`ifdef PIPE_STAGE_PERF_EN
    chk("rst_stall", {28'd0, stall_cycles}, 32'd0);
`endif
    rst = 1'b0;
    @(negedge clk);

    //   v  inv payload        ordy fl | ovld oinv opayload     irdy occ
    // streaming
    add(1, 0, 32'h10,        1, 0,   1, 0, 32'h10,        1, 1);
    add(1, 0, 32'h11,        1, 0,   1, 0, 32'h11,        1, 1);
    add(1, 0, 32'h12,        1, 0,   1, 0, 32'h12,        1, 1);
    add(0, 0, 32'h0,         1, 0,   0, 0, 32'h0,         1, 0);
    // backpressure
    add(1, 0, 32'hA0,        0, 0,   1, 0, 32'hA0,        1, 1);
    add(1, 0, 32'hA1,        0, 0,   1, 0, 32'hA0,        0, 2);
    add(1, 0, 32'hA2,        0, 0,   1, 0, 32'hA0,        0, 2);
    add(1, 0, 32'hA2,        1, 0,   1, 0, 32'hA1,        1, 1);
    add(1, 0, 32'hA2,        1, 0,   1, 0, 32'hA2,        1, 1);
    add(0, 0, 32'h0,         1, 0,   0, 0, 32'h0,         1, 0);
    // kill mask into main
    add(1, 1, 32'hFFFF_FFFF, 1, 0,   1, 1, 32'hFFFF_FFFA, 1, 1);
    add(1, 0, 32'hFFFF_FFFF, 1, 0,   1, 0, 32'hFFFF_FFFF, 1, 1);
    add(0, 0, 32'h0,         1, 0,   0, 0, 32'h0,         1, 0);
    // kill mask through skid
    add(1, 0, 32'h1234_5677, 0, 0,   1, 0, 32'h1234_5677, 1, 1);
    add(1, 1, 32'h0000_000F, 0, 0,   1, 0, 32'h1234_5677, 0, 2);
    add(0, 0, 32'h0,         1, 0,   1, 1, 32'h0000_000A, 1, 1);
    add(0, 0, 32'h0,         1, 0,   0, 0, 32'h0,         1, 0);
    // flush while FULL with an entry offered
    add(1, 0, 32'hB0,        0, 0,   1, 0, 32'hB0,        1, 1);
    add(1, 0, 32'hB1,        0, 0,   1, 0, 32'hB0,        0, 2);
    add(1, 0, 32'hB2,        0, 1,   0, 0, 32'h0,         1, 0);
    add(0, 0, 32'h0,         1, 0,   0, 0, 32'h0,         1, 0);
    // flush in HALF with accept&drain; flush in EMPTY with accept
    add(1, 0, 32'hD0,        0, 0,   1, 0, 32'hD0,        1, 1);
    add(1, 0, 32'hD1,        1, 1,   0, 0, 32'h0,         1, 0);
    add(1, 0, 32'hE0,        1, 1,   0, 0, 32'h0,         1, 0);
    add(0, 0, 32'h0,         1, 0,   0, 0, 32'h0,         1, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].v, vecs[i].inv, vecs[i].pay, vecs[i].ordy, vecs[i].fl);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_out_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].e_valid});
      chk($sformatf("v%0d_in_ready", i), {31'd0, in_ready}, {31'd0, vecs[i].e_irdy});
      chk($sformatf("v%0d_occupancy", i), {30'd0, occupancy}, {30'd0, vecs[i].e_occ});
      if (vecs[i].e_valid) begin
        chk($sformatf("v%0d_out_payload", i), out_payload, vecs[i].e_pay);
        chk($sformatf("v%0d_out_invalid", i), {31'd0, out_invalid}, {31'd0, vecs[i].e_inv});
      end
      $display("vec %0d: in_v=%0d inv=%0d pay=0x%0h ordy=%0d flush=%0d -> out_v=%0d out_inv=%0d out_pay=0x%0h in_rdy=%0d occ=%0d",
               i, vecs[i].v, vecs[i].inv, vecs[i].pay, vecs[i].ordy, vecs[i].fl,
               out_valid, out_invalid, out_payload, in_ready, occupancy);
    end

    // Asynchronous reset while FULL
    drive(1'b1, 1'b0, 32'hF0, 1'b0, 1'b0);
    @(posedge clk);
    drive(1'b1, 1'b0, 32'hF1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("ar_pre_occupancy", {30'd0, occupancy}, 32'd2);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_out_valid", {31'd0, out_valid}, 32'd0);
    chk("ar_out_payload", out_payload, 32'd0);
    chk("ar_occupancy", {30'd0, occupancy}, 32'd0);
    chk("ar_in_ready", {31'd0, in_ready}, 32'd1);
    $display("async reset: out_v=%0d out_pay=0x%0h occ=%0d in_rdy=%0d",
             out_valid, out_payload, occupancy, in_ready);
    #1;
    rst = 1'b0;
    drive(1'b1, 1'b0, 32'hC0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    chk("ar_c0_out_valid", {31'd0, out_valid}, 32'd1);
    chk("ar_c0_out_payload", out_payload, 32'hC0);
    $display("after reset: out_v=%0d out_pay=0x%0h", out_valid, out_payload);
    drive(1'b0, 1'b0, '0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    chk("ar_drain_occupancy", {30'd0, occupancy}, 32'd0);

`ifdef PIPE_STAGE_PERF_EN
    // Stall counter: saturation, flush immunity, reset clear
    #2;
    rst = 1'b1;
    #1;
    rst = 1'b0;
    drive(1'b1, 1'b0, 32'h1, 1'b0, 1'b0);
    @(posedge clk);
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (c == 4) chk("perf_stall_5", {28'd0, stall_cycles}, 32'd5);
    end
    chk("perf_stall_sat", {28'd0, stall_cycles}, 32'd15);
    $display("perf: stall_cycles=%0d after 20 stalled cycles", stall_cycles);
    drive(1'b0, 1'b0, '0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
    chk("perf_flush_out_valid", {31'd0, out_valid}, 32'd0);
    chk("perf_stall_after_flush", {28'd0, stall_cycles}, 32'd15);
    $display("perf: stall_cycles=%0d after flush", stall_cycles);
    #2;
    rst = 1'b1;
    #1;
    chk("perf_stall_after_rst", {28'd0, stall_cycles}, 32'd0);
    $display("perf: stall_cycles=%0d after rst", stall_cycles);
    rst = 1'b0;
`endif

    @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
